// File: rtl/lcd_power_sequencer_if.sv
// Panel power sequencer bus: power request, lock status and backlight duty in,
// rail enables, backlight and status out.
interface lcd_power_sequencer_if;
    logic       power_req;
    logic       mmcm_locked;
    logic [7:0] bl_duty;
    logic       panel_vdd_en;
    logic       lvds_en;
    logic       led_en;
    logic       led_pwm;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    modport master (
        output power_req, mmcm_locked, bl_duty,
        input  panel_vdd_en, lvds_en, led_en, led_pwm, ready, fault, state
    );

    modport slave (
        input  power_req, mmcm_locked, bl_duty,
        output panel_vdd_en, lvds_en, led_en, led_pwm, ready, fault, state
    );
endinterface

// File: rtl/lcd_power_sequencer.sv
// LVDS LCD panel power sequencer: orders panel VDD, LVDS enable and backlight on
// power-up/power-down with tick-based delays, waits for MMCM lock, flags lock faults
// and generates the 8-bit backlight PWM.
module lcd_power_sequencer #(
    parameter int unsigned TICK_DIV      = 72000,
    parameter int unsigned T_VDD_TO_LVDS = 10,
    parameter int unsigned T_LVDS_TO_BL  = 200,
    parameter int unsigned T_BL_TO_LVDS  = 200,
    parameter int unsigned T_LVDS_TO_VDD = 10,
    parameter int unsigned T_OFF_MIN     = 500,
    parameter int unsigned LOCK_TIMEOUT  = 50,
    parameter int unsigned PWM_DIV       = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    lcd_power_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_VDD_UP    = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_LVDS_UP   = 3'd3,
        S_ON        = 3'd4,
        S_BL_DOWN   = 3'd5,
        S_LVDS_DOWN = 3'd6,
        S_OFF_HOLD  = 3'd7
    } state_e;

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DW = 16;

    state_e          state_q, state_d;
    logic            preq_meta_q, psync_q, lock_meta_q, lsync_q;
    logic [TW-1:0]   div_q;
    logic            tick;
    logic [DW-1:0]   dly_q;
    logic [DW-1:0]   t_cur;
    logic            dly_done;
    logic            fault_q, fault_d;
    logic            vdd_q, vdd_d, lvds_q, lvds_d, led_q, led_d, ready_q, ready_d;
    logic [PW-1:0]   pdiv_q;
    logic            pwm_stb;
    logic [7:0]      pwm_cnt_q, duty_q;

    assign tick    = (div_q == TW'(TICK_DIV - 1));
    assign pwm_stb = (pdiv_q == PW'(PWM_DIV - 1));

    // Two-flop synchronisers for the asynchronous request and lock inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preq_meta_q <= 1'b0;
            psync_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lsync_q     <= 1'b0;
        end else begin
            preq_meta_q <= bus.power_req;
            psync_q     <= preq_meta_q;
            lock_meta_q <= bus.mmcm_locked;
            lsync_q     <= lock_meta_q;
        end
    end

    // Free-running tick and PWM step dividers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            pdiv_q <= '0;
        end else begin
            div_q  <= tick ? '0 : div_q + 1'b1;
            pdiv_q <= pwm_stb ? '0 : pdiv_q + 1'b1;
        end
    end

    // Delay counter: restarts on every state change, counts ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= '0;
        end else if (state_d != state_q) begin
            dly_q <= '0;
        end else if (tick) begin
            dly_q <= dly_q + 1'b1;
        end
    end

    // Delay target of the current state
    always_comb begin
        t_cur = '0;
        case (state_q)
            S_VDD_UP:    t_cur = DW'(T_VDD_TO_LVDS);
            S_WAIT_LOCK: t_cur = DW'(LOCK_TIMEOUT);
            S_LVDS_UP:   t_cur = DW'(T_LVDS_TO_BL);
            S_BL_DOWN:   t_cur = DW'(T_BL_TO_LVDS);
            S_LVDS_DOWN: t_cur = DW'(T_LVDS_TO_VDD);
            S_OFF_HOLD:  t_cur = DW'(T_OFF_MIN);
            default:     t_cur = '0;
        endcase
    end

    // Exit on the tick that closes the T-th whole tick period, so a timed state
    // lasts T..T+1 ticks whatever the phase of the free-running divider at entry.
    assign dly_done = tick && (dly_q == t_cur);

    // Next-state, fault and output decode
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            S_OFF: begin
                if (!psync_q)      fault_d = 1'b0;
                else if (!fault_q) state_d = S_VDD_UP;
            end
            S_VDD_UP: begin
                if (!psync_q)      state_d = S_LVDS_DOWN;
                else if (dly_done) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (!psync_q)      state_d = S_LVDS_DOWN;
                else if (lsync_q)  state_d = S_LVDS_UP;
                else if (dly_done) begin
                    fault_d = 1'b1;
                    state_d = S_LVDS_DOWN;
                end
            end
            S_LVDS_UP: begin
                if (!lsync_q) begin
                    fault_d = 1'b1;
                    state_d = S_BL_DOWN;
                end else if (!psync_q) state_d = S_LVDS_DOWN;
                else if (dly_done)     state_d = S_ON;
            end
            S_ON: begin
                if (!lsync_q) begin
                    fault_d = 1'b1;
                    state_d = S_BL_DOWN;
                end else if (!psync_q) state_d = S_BL_DOWN;
            end
            S_BL_DOWN:   if (dly_done) state_d = S_LVDS_DOWN;
            S_LVDS_DOWN: if (dly_done) state_d = S_OFF_HOLD;
            S_OFF_HOLD:  if (dly_done) state_d = S_OFF;
            default:     state_d = S_OFF;
        endcase

        vdd_d   = 1'b0;
        lvds_d  = 1'b0;
        led_d   = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            S_VDD_UP, S_WAIT_LOCK, S_LVDS_DOWN: vdd_d = 1'b1;
            S_LVDS_UP, S_BL_DOWN: begin
                vdd_d  = 1'b1;
                lvds_d = 1'b1;
            end
            S_ON: begin
                vdd_d   = 1'b1;
                lvds_d  = 1'b1;
                led_d   = 1'b1;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, fault and registered enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            fault_q <= 1'b0;
            vdd_q   <= 1'b0;
            lvds_q  <= 1'b0;
            led_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            vdd_q   <= vdd_d;
            lvds_q  <= lvds_d;
            led_q   <= led_d;
            ready_q <= ready_d;
        end
    end

    // PWM counter; duty is only taken at the period wrap to avoid mid-period glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else if (!led_q) begin
            pwm_cnt_q <= '0;
            duty_q    <= bus.bl_duty;
        end else if (pwm_stb) begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == 8'hFF) duty_q <= bus.bl_duty;
        end
    end

    assign bus.panel_vdd_en = vdd_q;
    assign bus.lvds_en      = lvds_q;
    assign bus.led_en       = led_q;
    assign bus.led_pwm      = led_q & (pwm_cnt_q < duty_q);
    assign bus.ready        = ready_q;
    assign bus.fault        = fault_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Directed bench for lcd_power_sequencer with short delays (tick = 4 clk).
module tb_lcd_power_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_power_sequencer_if bus();

    lcd_power_sequencer #(
        .TICK_DIV(4), .T_VDD_TO_LVDS(3), .T_LVDS_TO_BL(3), .T_BL_TO_LVDS(3),
        .T_LVDS_TO_VDD(3), .T_OFF_MIN(5), .LOCK_TIMEOUT(6), .PWM_DIV(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log gathered on the falling edge
    logic [2:0] prev_state = 3'd0;
    logic p_vdd = 1'b0, p_lvds = 1'b0, p_led = 1'b0, p_fault = 1'b0;
    int   seq[$];
    int   t_enter[8];
    int   t_vdd_r = 0, t_vdd_f = 0, t_lvds_r = 0, t_lvds_f = 0;
    int   t_led_r = 0, t_led_f = 0, t_fault_r = 0;
    int   lvds_cnt = 0, pwm_bad_cnt = 0;

    always @(negedge clk) begin
        if (bus.state != prev_state) begin
            seq.push_back(int'(bus.state));
            t_enter[bus.state] <= cyc;
        end
        prev_state <= bus.state;
        p_vdd   <= bus.panel_vdd_en;
        p_lvds  <= bus.lvds_en;
        p_led   <= bus.led_en;
        p_fault <= bus.fault;
        if (bus.panel_vdd_en && !p_vdd) t_vdd_r <= cyc;
        if (!bus.panel_vdd_en && p_vdd) t_vdd_f <= cyc;
        if (bus.lvds_en && !p_lvds)     t_lvds_r <= cyc;
        if (!bus.lvds_en && p_lvds)     t_lvds_f <= cyc;
        if (bus.led_en && !p_led)       t_led_r <= cyc;
        if (!bus.led_en && p_led)       t_led_f <= cyc;
        if (bus.fault && !p_fault)      t_fault_r <= cyc;
        if (bus.lvds_en)                lvds_cnt <= lvds_cnt + 1;
        if (bus.led_pwm && !bus.led_en) pwm_bad_cnt <= pwm_bad_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int seq_at(input int i);
        return (i < seq.size()) ? seq[i] : -1;
    endfunction

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        while (int'(bus.state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, int'(bus.state), s);
    endtask

    function automatic int outs();
        return int'({bus.panel_vdd_en, bus.lvds_en, bus.led_en, bus.led_pwm, bus.ready, bus.fault});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, high, n, t0, lv0;
        logic prevp;
        bus.power_req   = 1'b0;
        bus.mmcm_locked = 1'b0;
        bus.bl_duty     = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_outs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("idle_off", int'(bus.state), 0);

        // 1) Power-up
        base = seq.size();
        bus.bl_duty     = 8'd64;
        bus.mmcm_locked = 1'b1;
        bus.power_req   = 1'b1;
        wait_state(4, 300, "up_reach_on");
        check("up_seq_len", seq.size() - base, 4);
        check("up_seq0", seq_at(base), 1);
        check("up_seq1", seq_at(base + 1), 2);
        check("up_seq2", seq_at(base + 2), 3);
        check("up_seq3", seq_at(base + 3), 4);
        check("up_vdd_to_lvds_ge12", int'((t_lvds_r - t_vdd_r) >= 12), 1);
        check("up_lvds_to_led_ge12", int'((t_led_r - t_lvds_r) >= 12), 1);
        check("up_ready", int'(bus.ready), 1);
        check("up_fault", int'(bus.fault), 0);

        // 6) PWM at duty 64 over one full period
        high = 0;
        repeat (256) begin
            @(negedge clk);
            high += int'(bus.led_pwm);
        end
        check("pwm_64", high, 64);
        // Align to the period start: led_pwm rises only at count 0
        n = 0;
        prevp = bus.led_pwm;
        @(negedge clk);
        while (!(bus.led_pwm && !prevp) && n < 300) begin
            prevp = bus.led_pwm;
            @(negedge clk);
            n++;
        end
        check("pwm_align", int'(bus.led_pwm), 1);
        repeat (100) @(negedge clk);
        bus.bl_duty = 8'd128;
        high = 0;
        repeat (155) begin
            @(negedge clk);
            high += int'(bus.led_pwm);
        end
        check("pwm_mid_change_held", high, 0);
        high = 0;
        repeat (256) begin
            @(negedge clk);
            high += int'(bus.led_pwm);
        end
        check("pwm_128", high, 128);
        bus.bl_duty = 8'd0;
        repeat (256) @(negedge clk);
        high = 0;
        repeat (256) begin
            @(negedge clk);
            high += int'(bus.led_pwm);
        end
        check("pwm_zero", high, 0);
        bus.bl_duty = 8'd64;

        // 2) Power-down
        base = seq.size();
        bus.power_req = 1'b0;
        wait_state(7, 200, "dn_reach_hold");
        wait_state(0, 100, "dn_reach_off");
        check("dn_seq0", seq_at(base), 5);
        check("dn_seq1", seq_at(base + 1), 6);
        check("dn_seq2", seq_at(base + 2), 7);
        check("dn_seq3", seq_at(base + 3), 0);
        check("dn_led_to_lvds", int'((t_lvds_f - t_led_f) >= 12 && (t_lvds_f - t_led_f) <= 16), 1);
        check("dn_lvds_to_vdd", int'((t_vdd_f - t_lvds_f) >= 12 && (t_vdd_f - t_lvds_f) <= 16), 1);
        check("dn_hold_ge20", int'((t_enter[0] - t_enter[7]) >= 20), 1);
        check("dn_pwm_without_led", pwm_bad_cnt, 0);
        check("dn_outs", outs(), 0);

        // 3) Lock timeout
        base = seq.size();
        lv0 = lvds_cnt;
        bus.mmcm_locked = 1'b0;
        bus.power_req   = 1'b1;
        wait_state(2, 100, "to_reach_wait");
        n = 0;
        while (!bus.fault && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("to_fault_set", int'(bus.fault), 1);
        check("to_fault_24_28", int'((t_fault_r - t_enter[2]) >= 24 && (t_fault_r - t_enter[2]) <= 28), 1);
        wait_state(0, 200, "to_reach_off");
        check("to_seq2", seq_at(base + 2), 6);
        check("to_seq3", seq_at(base + 3), 7);
        check("to_no_lvds", lvds_cnt - lv0, 0);
        repeat (40) @(negedge clk);
        #1;
        check("to_no_restart", int'(bus.state), 0);
        check("to_fault_sticky", int'(bus.fault), 1);
        bus.power_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("to_fault_clear", int'(bus.fault), 0);

        // 4) Lock loss in ON
        base = seq.size();
        bus.mmcm_locked = 1'b1;
        bus.power_req   = 1'b1;
        wait_state(4, 300, "ll_reach_on");
        @(negedge clk);
        t0 = cyc;
        bus.mmcm_locked = 1'b0;
        wait_state(5, 20, "ll_bl_down");
        check("ll_latency", t_enter[5] - t0, 3);
        check("ll_fault", int'(bus.fault), 1);
        wait_state(0, 200, "ll_reach_off");
        check("ll_seq5", seq_at(base + 5), 6);
        check("ll_seq6", seq_at(base + 6), 7);
        bus.power_req   = 1'b0;
        bus.mmcm_locked = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("ll_fault_clear", int'(bus.fault), 0);

        // 5) Abort in VDD_UP, re-request during OFF_HOLD
        base = seq.size();
        lv0 = lvds_cnt;
        bus.power_req = 1'b1;
        wait_state(1, 50, "ab_reach_vdd");
        bus.power_req = 1'b0;
        wait_state(6, 20, "ab_lvds_down");
        wait_state(7, 50, "ab_reach_hold");
        bus.power_req = 1'b1;
        wait_state(0, 100, "ab_reach_off");
        check("ab_no_lvds", lvds_cnt - lv0, 0);
        wait_state(1, 20, "ab_restart");
        check("ab_seq1", seq_at(base + 1), 6);
        check("ab_seq3", seq_at(base + 3), 0);
        check("ab_seq4", seq_at(base + 4), 1);

        // Asynchronous reset mid-sequence
        wait_state(3, 100, "mr_reach_lvds_up");
        #2;
        rst = 1'b1;
        #1;
        check("mr_outs", outs(), 0);
        check("mr_state", int'(bus.state), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.power_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
